instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Front-end fetch stage directly upstream of the instruction memory. Owns the program counter and drives the memory word address. Captures the instruction returned in the same cycle into a small buffer and presents {pc, instruction} pairs to the decode stage over a valid/ready handshake. Supports branch/jump redirect with flush, and a halt input.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
DEPTH, 2, fetch buffer entries; legal values are 2 and 4.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
imem_addr  output  32  byte address to instruction memory; equals the PC register.
imem_instr  input  32  instruction word; combinational from imem_addr in the same cycle.
halt  input  1  while high, no new fetches; buffer continues to drain.
redirect_valid  input  1  branch/jump taken; load redirect_pc and flush.
redirect_pc  input  32  redirect target; bits [1:0] forced to 0.
out_valid  output  1  buffer head holds a valid entry.
out_ready  input  1  decode accepts head this cycle.
out_pc  output  32  PC of head entry.
out_instr  output  32  instruction of head entry.
out_pc_plus4  output  32  out_pc + 4, mod 2^32.

Behaviour:
- Reset (async assert, sync deassert, external): pc=RESET_PC, count=0, out_valid=0, out_pc=0, out_instr=0, out_pc_plus4=4.
- When empty, out_pc and out_instr read 0 and out_pc_plus4 reads 4.
- imem_addr = pc register, with no combinational path from any input.
- pop = out_valid & out_ready.
- push = !reset & !halt & !redirect_valid & (count<DEPTH | pop).
- On push, the entry {pc, imem_instr} is written at the tail and pc <= pc+4.
- PC wraps from 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
- The pop and push can happen in the same cycle when full; count is unchanged.
- Entries are presented in order; head output changes only on the edge after a pop or a push into an empty buffer.
- Latency: an entry pushed in cycle N shows out_valid=1 in cycle N+1.
  - After reset deassert, the first entry (RESET_PC) is visible one cycle later.
- Throughput: one instruction per cycle while out_ready=1 and halt=0.
- Redirect (priority over everything):
  - In cycle N, a pop that also occurs in cycle N still counts as a transfer.
  - At the end of cycle N: count<=0 and pc<=redirect_pc&~3, with no push.
  - Cycle N+1 fetches the target; cycle N+2 shows out_valid with out_pc=target. The penalty is 2 cycles.
- Halt: pc holds and no push, but pops continue. Deasserting halt resumes fetch from the held pc in that cycle.
- Halt and redirect together: redirect is applied (pc loaded, flush). Fetch then stays stopped until halt drops.
- Full with out_ready=0: no push, pc holds; imem_addr stays stable.
- Reset mid-operation: all entries are discarded immediately and outputs return to reset values asynchronously.
- No X-propagation: an empty buffer never exposes stale data.

Decomposition:
- Shared package:
  - INSTR_W=32, PC_W=32, PC_STEP=4.
  - Default RESET_PC.
  - Packed struct fetch_entry_t {pc[31:0], instr[31:0]}.
- One sub-module, fetch_buffer: a parameterised DEPTH FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, head.
  - Power-of-two wrap pointers plus a count.
  - Flush has priority over push.
- The top level holds the PC register, push/pop logic and output muxing.

Test Plan:
- Reset with RESET_PC=0x100, out_ready=1 for 5 cycles -> out_pc sequence 0x100,0x104,0x108,0x10C, one per cycle from cycle 1; out_instr matches memory words 64..67.
- out_ready=0 from reset -> after 2 pushes, count=DEPTH=2 and imem_addr holds at RESET_PC+8. Raise out_ready -> entries 0x0,0x4 then 0x8 with no gap or duplicate.
- Redirect to 0x203 in cycle 6 while 2 entries are buffered -> entries discarded, cycle 7 imem_addr=0x200, cycle 8 out_valid=1 with out_pc=0x200.
- Halt high for 4 cycles during streaming -> imem_addr constant, buffer drains to empty (out_valid=0). Halt low -> streaming resumes at the held PC, with no skipped address.
- Redirect to 0xFFFF_FFFC, out_ready=1 -> out_pc 0xFFFF_FFFC then 0x0000_0000; out_pc_plus4 reads 0x0 for the first entry.
- Async reset pulse mid-cycle while full -> out_valid drops immediately without waiting for clk. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared widths, reset default and fetch entry type
package instruction_fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam logic [PC_W-1:0] PC_STEP          = 32'd4;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// rtl/instruction_fetch_unit_fetch_buffer.sv - small in-order FIFO of fetch entries
module fetch_buffer
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  fetch_entry_t  r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  // Flush wins over push so a redirect never keeps a wrong-path entry.
  assign w_do_push = push & ~flush;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the top masks the head whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wr_entry;
  end

  assign full  = (r_count == LP_FULL_CNT);
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC register, fetch push/pop control and decode-side output
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc_plus4
);

  logic [PC_W-1:0] r_pc;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  fetch_entry_t    w_head;
  fetch_entry_t    w_wr_entry;

  assign w_pop  = out_valid & out_ready;
  assign w_push = ~reset & ~halt & ~redirect_valid & (~w_full | w_pop);

  assign w_wr_entry.pc    = r_pc;
  assign w_wr_entry.instr = imem_instr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[PC_W-1:2], 2'b00};
    end else if (w_push) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_fetch_buffer (
    .clk      (clk),
    .reset    (reset),
    .push     (w_push),
    .pop      (w_pop),
    .flush    (redirect_valid),
    .wr_entry (w_wr_entry),
    .full     (w_full),
    .empty    (w_empty),
    .head     (w_head)
  );

  assign imem_addr = r_pc;

  // Empty buffer reads as zero so stale or uninitialised storage never leaks out.
  assign out_valid    = ~w_empty;
  assign out_pc       = w_empty ? '0 : w_head.pc;
  assign out_instr    = w_empty ? '0 : w_head.instr;
  assign out_pc_plus4 = out_pc + PC_STEP;

endmodule
